// File: rtl/ysyx_22040931_jump_unit.sv
// ysyx_22040931_jump_unit
// Registered control-transfer unit for the execute stage. It decodes JAL, JALR
// and the six conditional branches, resolves taken/not-taken, the target and
// the link address. A return-address stack predicts JALR return targets and
// flags return mispredicts. Results sit in a one-entry output register behind
// a valid/ready handshake.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   flush             discard the registered beat, accept nothing this cycle
//   in_valid/in_ready input handshake (in_ready is combinational)
//   pc, inst          instruction PC and word
//   rs1_data/rs2_data source operands
//   out_valid/out_ready output handshake
//   jump, target      taken flag and resolved target (0 when not taken)
//   link              pc + 4
//   jtype, btype      JAL/JALR and conditional-branch class flags
//   illegal           branch opcode with reserved funct3 (010/011)
//   aluop, exop       execute-stage operation codes
//   ras_valid/ras_pred/ras_miss  return-address prediction and mispredict
module ysyx_22040931_jump_unit #(
    parameter int unsigned             XLEN        = 64,
    parameter int unsigned             RAS_DEPTH   = 4,
    parameter int unsigned             ALU_W       = 6,
    parameter int unsigned             EXOP_W      = 3,
    parameter logic [ALU_W-1:0]        ALU_ARITH   = '0,
    parameter logic [EXOP_W-1:0]       EXOP_JUMP   = EXOP_W'(1),
    parameter logic [EXOP_W-1:0]       EXOP_BRANCH = EXOP_W'(2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     pc,
    input  logic [31:0]         inst,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                jump,
    output logic [XLEN-1:0]     target,
    output logic [XLEN-1:0]     link,
    output logic                jtype,
    output logic                btype,
    output logic                illegal,
    output logic [ALU_W-1:0]    aluop,
    output logic [EXOP_W-1:0]   exop,
    output logic                ras_valid,
    output logic [XLEN-1:0]     ras_pred,
    output logic                ras_miss
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [6:0] {
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    // ------------------------------------------------------------------
    // Output register and RAS state
    // ------------------------------------------------------------------
    logic                r_valid;
    logic                r_jump;
    logic [XLEN-1:0]     r_target;
    logic [XLEN-1:0]     r_link;
    logic                r_jtype;
    logic                r_btype;
    logic                r_illegal;
    logic [ALU_W-1:0]    r_aluop;
    logic [EXOP_W-1:0]   r_exop;
    logic                r_ras_valid;
    logic [XLEN-1:0]     r_ras_pred;
    logic                r_ras_miss;

    logic [XLEN-1:0]     r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]    r_ptr;   // next free slot; top entry is r_ptr-1
    logic [CNT_W-1:0]    r_cnt;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]          w_opcode;
    logic [4:0]          w_rd;
    logic [4:0]          w_rs1;
    logic [2:0]          w_funct3;
    logic                w_is_jal;
    logic                w_is_jalr;
    logic                w_is_br;
    logic [XLEN-1:0]     w_imm_i;
    logic [XLEN-1:0]     w_imm_j;
    logic [XLEN-1:0]     w_imm_b;
    logic [XLEN-1:0]     w_link;
    logic [XLEN-1:0]     w_jalr_sum;
    logic                w_accept;

    assign w_opcode  = inst[6:0];
    assign w_rd      = inst[11:7];
    assign w_funct3  = inst[14:12];
    assign w_rs1     = inst[19:15];
    assign w_is_jal  = (w_opcode == OP_JAL);
    assign w_is_jalr = (w_opcode == OP_JALR);
    assign w_is_br   = (w_opcode == OP_BRANCH);

    assign w_imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign w_imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20],
                      inst[30:21], 1'b0};
    assign w_imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25],
                      inst[11:8], 1'b0};

    assign w_link     = pc + XLEN'(4);
    assign w_jalr_sum = rs1_data + w_imm_i;

    assign in_ready = !flush && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Branch condition
    // ------------------------------------------------------------------
    logic w_take;
    logic w_br_ill;

    always_comb begin
        w_take   = 1'b0;
        w_br_ill = 1'b0;
        unique case (w_funct3)
            3'b000:  w_take = (rs1_data == rs2_data);
            3'b001:  w_take = (rs1_data != rs2_data);
            3'b100:  w_take = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  w_take = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  w_take = (rs1_data <  rs2_data);
            3'b111:  w_take = (rs1_data >= rs2_data);
            default: w_br_ill = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Result computation
    // ------------------------------------------------------------------
    logic                w_jump;
    logic [XLEN-1:0]     w_target;
    logic                w_jtype;
    logic                w_btype;
    logic                w_illegal;
    logic [ALU_W-1:0]    w_aluop;
    logic [EXOP_W-1:0]   w_exop;

    always_comb begin
        w_jump    = 1'b0;
        w_target  = '0;
        w_jtype   = 1'b0;
        w_btype   = 1'b0;
        w_illegal = 1'b0;
        w_aluop   = '0;
        w_exop    = '0;
        if (w_is_jal) begin
            w_jump   = 1'b1;
            w_target = pc + w_imm_j;
            w_jtype  = 1'b1;
            w_aluop  = ALU_ARITH;
            w_exop   = EXOP_JUMP;
        end else if (w_is_jalr) begin
            w_jump   = 1'b1;
            w_target = w_jalr_sum & ~XLEN'(1);
            w_jtype  = 1'b1;
            w_aluop  = ALU_ARITH;
            w_exop   = EXOP_JUMP;
        end else if (w_is_br) begin
            w_btype   = 1'b1;
            w_aluop   = ALU_ARITH;
            w_exop    = EXOP_BRANCH;
            w_illegal = w_br_ill;
            w_jump    = w_take && !w_br_ill;
            if (w_jump) begin
                w_target = pc + w_imm_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Return-address stack actions (x1/x5 are link registers)
    // ------------------------------------------------------------------
    logic                w_rd_link;
    logic                w_rs1_link;
    logic                w_push;
    logic                w_pop;
    logic                w_hit;
    logic [PTR_W-1:0]    w_top;
    logic [XLEN-1:0]     w_pred;
    logic                w_miss;

    assign w_rd_link  = (w_rd  == 5'd1) || (w_rd  == 5'd5);
    assign w_rs1_link = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);

    always_comb begin
        w_push = 1'b0;
        w_pop  = 1'b0;
        if (w_is_jal) begin
            w_push = w_rd_link;
        end else if (w_is_jalr) begin
            unique case ({w_rd_link, w_rs1_link})
                2'b10: w_push = 1'b1;
                2'b01: w_pop  = 1'b1;
                2'b11: begin
                    w_push = 1'b1;
                    w_pop  = (w_rd != w_rs1);
                end
                default: ;
            endcase
        end
    end

    assign w_top  = r_ptr - PTR_W'(1);
    assign w_hit  = w_pop && (r_cnt != '0);
    assign w_pred = w_hit ? r_ras[w_top] : '0;
    assign w_miss = w_hit && (w_pred != w_target);

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_jump      <= 1'b0;
            r_target    <= '0;
            r_link      <= '0;
            r_jtype     <= 1'b0;
            r_btype     <= 1'b0;
            r_illegal   <= 1'b0;
            r_aluop     <= '0;
            r_exop      <= '0;
            r_ras_valid <= 1'b0;
            r_ras_pred  <= '0;
            r_ras_miss  <= 1'b0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_jump      <= w_jump;
            r_target    <= w_target;
            r_link      <= w_link;
            r_jtype     <= w_jtype;
            r_btype     <= w_btype;
            r_illegal   <= w_illegal;
            r_aluop     <= w_aluop;
            r_exop      <= w_exop;
            r_ras_valid <= w_hit;
            r_ras_pred  <= w_pred;
            r_ras_miss  <= w_miss;
            // Pop-then-push collapses to an in-place overwrite of the top.
            if (w_hit && w_push) begin
                r_ras[w_top] <= w_link;
            end else if (w_hit) begin
                r_ptr <= w_top;
                r_cnt <= r_cnt - CNT_W'(1);
            end else if (w_push) begin
                r_ras[r_ptr] <= w_link;
                r_ptr        <= r_ptr + PTR_W'(1);
                if (r_cnt != CNT_W'(RAS_DEPTH)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign jump      = r_jump;
    assign target    = r_target;
    assign link      = r_link;
    assign jtype     = r_jtype;
    assign btype     = r_btype;
    assign illegal   = r_illegal;
    assign aluop     = r_aluop;
    assign exop      = r_exop;
    assign ras_valid = r_ras_valid;
    assign ras_pred  = r_ras_pred;
    assign ras_miss  = r_ras_miss;

endmodule
